// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch stage with redirect, drain and sticky error halt
module instruction_fetch #(
    parameter int unsigned            XLEN       = 32,
    parameter logic [XLEN-1:0]        RESET_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] pc_o,
    output logic            err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_out;
    logic            r_err;
    logic            w_capture;
    logic            w_set_err;
    logic            w_redir_ok;
    logic            w_redir_bad;

    assign w_redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign w_redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    // A misaligned redirect wins over everything else; HALT absorbs any response still in flight.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_capture    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_redir_bad) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    if (w_redir_ok) begin
                        w_pc_next = redirect_pc_i;
                    end
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_redir_bad) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end else if (w_redir_ok) begin
                    w_pc_next    = redirect_pc_i;
                    w_state_next = S_DRAIN;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir_bad) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end else if (w_redir_ok) begin
                    w_pc_next    = redirect_pc_i;
                    w_state_next = imem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    if (imem_err_i) begin
                        w_set_err    = 1'b1;
                        w_state_next = S_HALT;
                    end else begin
                        w_capture    = 1'b1;
                        w_pc_next    = r_pc + PC_STEP;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                if (w_redir_bad) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    if (w_redir_ok) begin
                        w_pc_next = redirect_pc_i;
                    end
                    if (imem_rvalid_i) begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (w_redir_bad) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end else if (w_redir_ok) begin
                    w_pc_next    = redirect_pc_i;
                    w_state_next = S_REQ;
                end else if (instr_ready_i) begin
                    w_state_next = S_REQ;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_ADDR;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_capture) begin
                r_instr  <= imem_rdata_i;
                r_pc_out <= r_pc;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_req_o    = (r_state == S_REQ);
    assign imem_addr_o   = (r_state == S_REQ) ? r_pc : '0;
    assign instr_valid_o = (r_state == S_HOLD);
    assign instruction_o = r_instr;
    assign pc_o          = r_pc_out;
    assign err_o         = r_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rvalid;
    logic [31:0] rdata;
    logic        berr;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;

    logic        req, valid, err;
    logic [31:0] addr, instr, pc_out;
    logic        d2_req, d2_valid, d2_err;
    logic [31:0] d2_addr, d2_instr, d2_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.XLEN(32), .RESET_ADDR(32'h0000_0000)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(berr),
        .redirect_i(redir), .redirect_pc_i(redir_pc),
        .instr_valid_o(valid), .instr_ready_i(ready),
        .instruction_o(instr), .pc_o(pc_out), .err_o(err)
    );

    instruction_fetch #(.XLEN(32), .RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(d2_req), .imem_addr_o(d2_addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(berr),
        .redirect_i(redir), .redirect_pc_i(redir_pc),
        .instr_valid_o(d2_valid), .instr_ready_i(ready),
        .instruction_o(d2_instr), .pc_o(d2_pc), .err_o(d2_err)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1300_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts in REQ, returns in HOLD with the fetched word presented.
    task automatic serve(input logic [31:0] a);
        chk("req_pulse", {31'b0, req}, 32'd1);
        chk("req_addr", addr, a);
        tick();
        chk("wait_no_req", {31'b0, req}, 32'd0);
        rvalid = 1'b1;
        rdata  = word_at(a);
        tick();
        rvalid = 1'b0;
        rdata  = 32'hDEAD_BEEF;
        chk("hold_valid", {31'b0, valid}, 32'd1);
        chk("hold_pc", pc_out, a);
        chk("hold_instr", instr, word_at(a));
    endtask

    initial begin
        rst_n = 1'b0; rvalid = 1'b0; rdata = '0; berr = 1'b0;
        redir = 1'b0; redir_pc = '0; ready = 1'b1;
        tick();
        tick();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);

        // Sequential fetch with ready held high; wrap instance runs in lockstep.
        rst_n = 1'b1;
        tick();
        chk("wrap_first_addr", d2_addr, 32'hFFFF_FFFC);
        serve(32'h0);
        tick();
        chk("wrap_second_addr", d2_addr, 32'h0);
        chk("wrap_second_req", {31'b0, d2_req}, 32'd1);
        serve(32'h4);
        tick();
        serve(32'h8);

        // Back-pressure: held word stays put, no new request.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, valid}, 32'd1);
            chk("stall_pc", pc_out, 32'h8);
            chk("stall_instr", instr, word_at(32'h8));
            chk("stall_no_req", {31'b0, req}, 32'd0);
        end
        ready = 1'b1;
        tick();
        serve(32'hC);

        // Redirect during WAIT, response arrives later and is drained.
        tick();
        chk("pre_redir_addr", addr, 32'h10);
        tick();
        redir = 1'b1; redir_pc = 32'h100;
        tick();
        redir = 1'b0;
        chk("drain_no_req", {31'b0, req}, 32'd0);
        chk("drain_no_valid", {31'b0, valid}, 32'd0);
        tick();
        chk("drain_still", {31'b0, req}, 32'd0);
        rvalid = 1'b1; rdata = 32'hBAD0_0010;
        tick();
        rvalid = 1'b0;
        chk("drain_dropped", {31'b0, valid}, 32'd0);
        serve(32'h100);

        // Redirect coinciding with the response in WAIT.
        tick();
        chk("pre_coinc_addr", addr, 32'h104);
        tick();
        rvalid = 1'b1; rdata = 32'hBAD0_0104; redir = 1'b1; redir_pc = 32'h200;
        tick();
        rvalid = 1'b0; redir = 1'b0;
        chk("coinc_no_valid", {31'b0, valid}, 32'd0);
        serve(32'h200);

        // Redirect in HOLD while the instruction is being accepted.
        redir = 1'b1; redir_pc = 32'h300;
        tick();
        redir = 1'b0;
        chk("hold_redir_valid", {31'b0, valid}, 32'd0);
        serve(32'h300);

        // Bus error halts the fetcher until reset.
        tick();
        chk("pre_err_addr", addr, 32'h304);
        tick();
        rvalid = 1'b1; berr = 1'b1; rdata = 32'hBAD0_0304;
        tick();
        rvalid = 1'b0; berr = 1'b0;
        chk("buserr_err", {31'b0, err}, 32'd1);
        chk("buserr_valid", {31'b0, valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_no_req", {31'b0, req}, 32'd0);
        end

        // Reset clears the halt; a late response before the first REQ is ignored.
        rst_n = 1'b0;
        tick();
        chk("rerst_err", {31'b0, err}, 32'd0);
        chk("rerst_pc", pc_out, 32'h0);
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_FFFF;
        tick();
        rvalid = 1'b0;
        chk("late_no_valid", {31'b0, valid}, 32'd0);
        serve(32'h0);

        // Misaligned redirect forces HALT with err set.
        ready = 1'b0; redir = 1'b1; redir_pc = 32'h102;
        tick();
        redir = 1'b0;
        chk("misalign_err", {31'b0, err}, 32'd1);
        chk("misalign_valid", {31'b0, valid}, 32'd0);
        chk("misalign_req", {31'b0, req}, 32'd0);
        ready = 1'b1;
        tick();
        chk("misalign_halt_req", {31'b0, req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_ADDR, 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_ni  input  1  reset, synchronous, active-low.
REQ-004 Port: imem_req_o  output  1  fetch request, one-cycle pulse.
REQ-005 Port: imem_addr_o  output  XLEN  fetch address, valid while imem_req_o=1.
REQ-006 Port: imem_rvalid_i  input  1  response valid, at least 1 cycle after request.
REQ-007 Port: imem_rdata_i  input  XLEN  fetched instruction word.
REQ-008 Port: imem_err_i  input  1  bus error, qualified by imem_rvalid_i.
REQ-009 Port: redirect_i  input  1  taken JAL/BNE; load new PC.
REQ-010 Port: redirect_pc_i  input  XLEN  redirect target.
REQ-011 Port: instr_valid_o  output  1  instruction_o/pc_o valid towards instruction_decoder.
REQ-012 Port: instr_ready_i  input  1  decode stage accepts instruction.
REQ-013 Port: instruction_o  output  XLEN  registered instruction word; feeds instruction_i of instruction_decoder.
REQ-014 Port: pc_o  output  XLEN  address of instruction_o.
REQ-015 Port: err_o  output  1  sticky fetch error.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DRAIN, HOLD, HALT; exactly one outstanding memory request at any time.
REQ-017 IDLE -> REQ unconditionally, next cycle.
REQ-018 REQ: imem_req_o=1, imem_addr_o=pc_q; -> WAIT; imem_req_o=0 in every other state.
REQ-019 WAIT, imem_rvalid_i=1, imem_err_i=0: capture imem_rdata_i into instruction_o, pc_q into pc_o, pc_q <= pc_q+4; -> HOLD.
REQ-020 PC increment SHALL be modulo 2^XLEN (32'hFFFF_FFFC + 4 = 32'h0).
REQ-021 HOLD: instr_valid_o=1, instruction_o/pc_o stable; instr_ready_i=1 -> REQ; otherwise stay in HOLD.
REQ-022 instr_valid_o SHALL be 1 only in HOLD; the fetch-to-valid latency is 2 cycles after the request cycle for a 1-cycle memory.
REQ-023 Redirect in IDLE or HOLD: pc_q <= redirect_pc_i, instr_valid_o=0 next cycle, -> REQ; a held instruction is dropped.
REQ-024 Redirect in HOLD with instr_ready_i=1: the handshake completes (instruction consumed) and the redirect still applies.
REQ-025 Redirect in REQ or WAIT without imem_rvalid_i: pc_q <= redirect_pc_i, -> DRAIN.
REQ-026 Redirect in WAIT with imem_rvalid_i=1: response discarded (even if errored), pc_q <= redirect_pc_i, -> REQ.
REQ-027 DRAIN: wait for imem_rvalid_i, discard data and imem_err_i, -> REQ; a further redirect in DRAIN updates pc_q only.
REQ-028 A redirect_pc_i with bits [1:0] != 0 SHALL set err_o, be ignored for pc_q, and force HALT next cycle; HALT still consumes one pending response without effect.
REQ-029 imem_rvalid_i=1 with imem_err_i=1 in WAIT (no redirect): err_o <= 1, -> HALT; the instruction is not presented.
REQ-030 HALT: no requests, instr_valid_o=0; leaves only through reset.
REQ-031 imem_rvalid_i outside WAIT/DRAIN/HALT SHALL be ignored.

Reset
REQ-032 While rst_ni=0 at a clock edge: state=IDLE, pc_q=RESET_ADDR, imem_req_o=0, imem_addr_o=0, instr_valid_o=0, instruction_o=0, pc_o=0, err_o=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; a late response after reset release SHALL be ignored until the first new REQ.

Verification
REQ-034 Reset release, 1-cycle memory, ready=1 -> requests at 0x0, 0x4, 0x8; instr_valid_o with pc_o=0x0, 0x4, 0x8 in order.
REQ-035 ready=0 for 5 cycles in HOLD -> instruction_o/pc_o stable, no new imem_req_o; ready=1 -> next request at pc_o+4.
REQ-036 Redirect to 0x100 in WAIT, response 2 cycles later -> response discarded; next request at 0x100.
REQ-037 Redirect to 0x200 coinciding with rvalid in WAIT -> no instr_valid_o for the old word; request at 0x200 next cycle.
REQ-038 imem_err_i=1 with rvalid -> err_o=1, no further requests until rst_ni=0; a misaligned redirect to 0x102 -> err_o=1, HALT.
REQ-039 RESET_ADDR=32'hFFFF_FFFC -> second request at 0x0.
